// File: rtl/wb_pkg.sv
// Shared widths and the writeback source select encoding for the register file write path.
package wb_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_MEM,
        WB_HOLD,
        WB_EX
    } wb_src_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write scoreboard and issue stall (RAW on sources, WAW on destination).
// With WB_BYPASS_EN, a register committing this cycle no longer blocks its readers.
module wb_scoreboard #(
    parameter int ADDR_W   = wb_pkg::ADDR_W,
    parameter int NUM_REGS = wb_pkg::NUM_REGS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_valid,
    input  logic                iss_wr,
    input  logic [ADDR_W-1:0]   iss_dst,
    input  logic [ADDR_W-1:0]   iss_src1,
    input  logic [ADDR_W-1:0]   iss_src2,
    input  logic                rf_we,
    input  logic [ADDR_W-1:0]   rf_waddr,
    output logic                iss_stall,
    output logic [NUM_REGS-1:0] busy_vec
);
    import wb_pkg::*;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] wr_mask;
    logic [NUM_REGS-1:0] src_busy;

    always_comb begin
        wr_mask = '0;
        if (rf_we) begin
            wr_mask[rf_waddr] = 1'b1;
        end
`ifdef WB_BYPASS_EN
        src_busy = busy_q & ~wr_mask;
`else
        src_busy = busy_q;
`endif
        // WAW always sees the unmasked vector so a register never has two writes in flight.
        iss_stall = iss_valid & (src_busy[iss_src1] | src_busy[iss_src2] |
                                 (iss_wr & busy_q[iss_dst]));
        busy_d = busy_q & ~wr_mask;
        if (iss_valid && iss_wr && !iss_stall) begin
            busy_d[iss_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Sequences MEM, held-ALU and ALU writebacks onto the single register file write port (MEM > HOLD > EX).
// Optional WB_BYPASS_EN forwards the in-flight write to the decode operand reads.
module regfile_wb_arbiter #(
    parameter int DATA_W   = wb_pkg::DATA_W,
    parameter int ADDR_W   = wb_pkg::ADDR_W,
    parameter int NUM_REGS = wb_pkg::NUM_REGS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_valid,
    input  logic                iss_wr,
    input  logic [ADDR_W-1:0]   iss_dst,
    input  logic [ADDR_W-1:0]   iss_src1,
    input  logic [ADDR_W-1:0]   iss_src2,
    output logic                iss_stall,
    input  logic                ex_valid,
    input  logic [ADDR_W-1:0]   ex_addr,
    input  logic [DATA_W-1:0]   ex_data,
    output logic                ex_ready,
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    input  logic [DATA_W-1:0]   rf_rdata1,
    input  logic [DATA_W-1:0]   rf_rdata2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    output logic [NUM_REGS-1:0] busy_vec
);
    import wb_pkg::*;

    wb_src_t             wb_sel;
    logic                hold_v_q,    hold_v_d;
    logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0]   hold_data_q, hold_data_d;
    logic                rf_we_q,     rf_we_d;
    logic [ADDR_W-1:0]   rf_waddr_q,  rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q,  rf_wdata_d;

    assign ex_ready = !hold_v_q;

    always_comb begin
        if (mem_valid) begin
            wb_sel = WB_MEM;
        end else if (hold_v_q) begin
            wb_sel = WB_HOLD;
        end else if (ex_valid) begin
            wb_sel = WB_EX;
        end else begin
            wb_sel = WB_NONE;
        end

        hold_v_d    = hold_v_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        // An accepted ALU result that loses to MEM is parked; hold drains only when MEM is idle.
        if (!hold_v_q && mem_valid && ex_valid) begin
            hold_v_d    = 1'b1;
            hold_addr_d = ex_addr;
            hold_data_d = ex_data;
        end else if (hold_v_q && !mem_valid) begin
            hold_v_d = 1'b0;
        end

        rf_we_d    = (wb_sel != WB_NONE);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        case (wb_sel)
            WB_MEM: begin
                rf_waddr_d = mem_addr;
                rf_wdata_d = mem_data;
            end
            WB_HOLD: begin
                rf_waddr_d = hold_addr_q;
                rf_wdata_d = hold_data_q;
            end
            WB_EX: begin
                rf_waddr_d = ex_addr;
                rf_wdata_d = ex_data;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v_q    <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
        end else begin
            hold_v_q    <= hold_v_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef WB_BYPASS_EN
    assign rd_data1 = (rf_we_q && (rf_waddr_q == rd_addr1)) ? rf_wdata_q : rf_rdata1;
    assign rd_data2 = (rf_we_q && (rf_waddr_q == rd_addr2)) ? rf_wdata_q : rf_rdata2;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd_addr1, rd_addr2};
    assign rd_data1 = rf_rdata1;
    assign rd_data2 = rf_rdata2;
`endif

    wb_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_wr    (iss_wr),
        .iss_dst   (iss_dst),
        .iss_src1  (iss_src1),
        .iss_src2  (iss_src2),
        .rf_we     (rf_we_q),
        .rf_waddr  (rf_waddr_q),
        .iss_stall (iss_stall),
        .busy_vec  (busy_vec)
    );
endmodule
